// File: rtl/acc_host_sequencer.sv
// -----------------------------------------------------------------------------
// acc_host_sequencer
// Host-side initiator for the accelerator datapath register block. Packs a
// stream of BUS_WIDTH beats into one IN_WIDTH word, writes it, pulses START,
// waits for DONE (or a timeout), returns the result over valid/ready and then
// clears the block with a STOP pulse.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready   host beat handshake, s_data = beat payload
//   abort             synchronous abort request, highest priority
//   ctrl_wr_en        control register write strobe
//   ctrl_start_wr     START value written (0 whenever ctrl_wr_en=0)
//   ctrl_stop_wr      STOP value written  (0 whenever ctrl_wr_en=0)
//   in_data_wr_en     input data register write strobe
//   in_data_wr        packed input word (driven straight from the shadow)
//   acc_busy          BUSY status, observed only
//   acc_done          DONE status
//   acc_out_data      captured result register
//   m_valid/m_ready   result handshake, m_data = result, m_timeout = qualifier
//   seq_busy          high unless idle in LOAD with no partial beats
// -----------------------------------------------------------------------------
module acc_host_sequencer #(
    parameter int IN_WIDTH       = 1024,
    parameter int OUT_WIDTH      = 4,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BUS_WIDTH-1:0] s_data,
    input  logic                 abort,
    output logic                 ctrl_wr_en,
    output logic                 ctrl_start_wr,
    output logic                 ctrl_stop_wr,
    output logic                 in_data_wr_en,
    output logic [IN_WIDTH-1:0]  in_data_wr,
    input  logic                 acc_busy,
    input  logic                 acc_done,
    input  logic [OUT_WIDTH-1:0] acc_out_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_timeout,
    output logic                 seq_busy
);

    localparam int NBEATS = IN_WIDTH / BUS_WIDTH;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_START_SET = 3'd2,
        ST_START_CLR = 3'd3,
        ST_WAIT      = 3'd4,
        ST_RESULT    = 3'd5,
        ST_CLEAR_SET = 3'd6,
        ST_CLEAR_CLR = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [IN_WIDTH-1:0]    shadow_q, shadow_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [OUT_WIDTH-1:0]   m_data_q, m_data_d;
    logic                   m_timeout_q, m_timeout_d;
    logic                   m_valid_q, m_valid_d;
    logic                   ctrl_wr_en_q, ctrl_wr_en_d;
    logic                   ctrl_start_wr_q, ctrl_start_wr_d;
    logic                   ctrl_stop_wr_q, ctrl_stop_wr_d;
    logic                   in_data_wr_en_q, in_data_wr_en_d;
    logic                   seq_busy_q, seq_busy_d;
    logic                   s_ready_s;
    logic                   unused_s;

    // BUSY is informational only; the sequence is driven by DONE.
    assign unused_s = acc_busy;

    // Ready must drop in the same cycle abort is raised, so it is decoded
    // combinationally from the state register.
    assign s_ready_s = (state_q == ST_LOAD) && !abort;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        shadow_d    = shadow_q;
        to_cnt_d    = to_cnt_q;
        m_data_d    = m_data_q;
        m_timeout_d = m_timeout_q;

        case (state_q)
            ST_LOAD: begin
                if (abort) begin
                    if (beat_cnt_q != {CNT_W{1'b0}}) begin
                        // Partial word is discarded so no stale beat survives.
                        beat_cnt_d = {CNT_W{1'b0}};
                        shadow_d   = {IN_WIDTH{1'b0}};
                        state_d    = ST_CLEAR_SET;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (s_valid && s_ready_s) begin
                    for (int k = 0; k < NBEATS; k++) begin
                        if (beat_cnt_q == CNT_W'(k)) begin
                            shadow_d[k*BUS_WIDTH +: BUS_WIDTH] = s_data;
                        end else begin
                            shadow_d[k*BUS_WIDTH +: BUS_WIDTH] = shadow_q[k*BUS_WIDTH +: BUS_WIDTH];
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = {CNT_W{1'b0}};
                        state_d    = ST_WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1'b1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE:     state_d = abort ? ST_CLEAR_SET : ST_START_SET;
            ST_START_SET: state_d = abort ? ST_CLEAR_SET : ST_START_CLR;
            ST_START_CLR: begin
                if (abort) begin
                    state_d = ST_CLEAR_SET;
                end else begin
                    state_d  = ST_WAIT;
                    to_cnt_d = {TO_W{1'b0}};
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_CLEAR_SET;
                end else if (acc_done) begin
                    // DONE wins over a coinciding final timeout count.
                    m_data_d    = acc_out_data;
                    m_timeout_d = 1'b0;
                    state_d     = ST_RESULT;
                end else if (to_cnt_q == TO_LAST) begin
                    m_data_d    = {OUT_WIDTH{1'b0}};
                    m_timeout_d = 1'b1;
                    state_d     = ST_RESULT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1'b1);
                end
            end
            ST_RESULT: begin
                if (abort || m_ready) begin
                    state_d = ST_CLEAR_SET;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            // Abort is ignored while clearing: STOP must always be followed by
            // its release write, otherwise the next DONE would be masked.
            ST_CLEAR_SET: state_d = ST_CLEAR_CLR;
            ST_CLEAR_CLR: state_d = ST_LOAD;
            default:      state_d = ST_LOAD;
        endcase

        // Outputs are registered: decode from the state being entered.
        in_data_wr_en_d = (state_d == ST_WRITE);
        ctrl_start_wr_d = (state_d == ST_START_SET);
        ctrl_stop_wr_d  = (state_d == ST_CLEAR_SET);
        ctrl_wr_en_d    = (state_d == ST_START_SET) || (state_d == ST_START_CLR) ||
                          (state_d == ST_CLEAR_SET) || (state_d == ST_CLEAR_CLR);
        m_valid_d       = (state_d == ST_RESULT);
        seq_busy_d      = !((state_d == ST_LOAD) && (beat_cnt_d == {CNT_W{1'b0}}));
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_LOAD;
            beat_cnt_q      <= {CNT_W{1'b0}};
            shadow_q        <= {IN_WIDTH{1'b0}};
            to_cnt_q        <= {TO_W{1'b0}};
            m_data_q        <= {OUT_WIDTH{1'b0}};
            m_timeout_q     <= 1'b0;
            m_valid_q       <= 1'b0;
            ctrl_wr_en_q    <= 1'b0;
            ctrl_start_wr_q <= 1'b0;
            ctrl_stop_wr_q  <= 1'b0;
            in_data_wr_en_q <= 1'b0;
            seq_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            shadow_q        <= shadow_d;
            to_cnt_q        <= to_cnt_d;
            m_data_q        <= m_data_d;
            m_timeout_q     <= m_timeout_d;
            m_valid_q       <= m_valid_d;
            ctrl_wr_en_q    <= ctrl_wr_en_d;
            ctrl_start_wr_q <= ctrl_start_wr_d;
            ctrl_stop_wr_q  <= ctrl_stop_wr_d;
            in_data_wr_en_q <= in_data_wr_en_d;
            seq_busy_q      <= seq_busy_d;
        end
    end

    assign s_ready       = s_ready_s;
    assign ctrl_wr_en    = ctrl_wr_en_q;
    assign ctrl_start_wr = ctrl_start_wr_q;
    assign ctrl_stop_wr  = ctrl_stop_wr_q;
    assign in_data_wr_en = in_data_wr_en_q;
    assign in_data_wr    = shadow_q;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign m_timeout     = m_timeout_q;
    assign seq_busy      = seq_busy_q;

endmodule
